// File: rtl/mem_access_seq.sv
// Memory access sequencer: word/byte loads and stores with optional pointer
// indirection, per-access wait timeout, and a valid/ready response channel.
module mem_access_seq #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int MAX_IND = 2,
    parameter int TIMEOUT = 255,
    localparam int NB = DATA_W / 8,
    localparam int LB = $clog2(NB),
    localparam int IW = (MAX_IND > 0) ? $clog2(MAX_IND + 1) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic [IW-1:0]     req_ind,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [NB-1:0]     mem_byte_enable,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    localparam int WW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_M1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [2:0] {IDLE, PTR, LOAD, STORE, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [IW-1:0]       ind_q, ind_d;
    logic                write_q, write_d;
    logic                byte_q, byte_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [WW-1:0]       wait_q, wait_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                req_ready_q, req_ready_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [NB-1:0]       mem_byte_enable_q, mem_byte_enable_d;

    logic                timed_out;
    logic [DATA_W-1:0]   rdata_shifted;

    assign timed_out     = (TIMEOUT != 0) && (wait_q == WW'(TO_M1));
    assign rdata_shifted = mem_rdata >> {addr_q[LB-1:0], 3'b000};

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        ind_d      = ind_q;
        write_d    = write_q;
        byte_d     = byte_q;
        wdata_d    = wdata_q;
        wait_d     = wait_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    ind_d      = req_ind;
                    write_d    = req_write;
                    byte_d     = req_byte;
                    wdata_d    = req_wdata;
                    wait_d     = '0;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                    if ((!req_byte && req_addr[LB-1:0] != '0) || req_ind > IW'(MAX_IND)) begin
                        state_d   = DONE;
                        rsp_err_d = 1'b1;
                    end else if (req_ind != '0) begin
                        state_d = PTR;
                    end else begin
                        state_d = req_write ? STORE : LOAD;
                    end
                end
            end
            PTR: begin
                if (mem_resp) begin
                    addr_d = mem_rdata[ADDR_W-1:0];
                    ind_d  = ind_q - IW'(1);
                    wait_d = '0;
                    if (ind_q != IW'(1)) begin
                        state_d = PTR;
                    end else if (!byte_q && mem_rdata[LB-1:0] != '0) begin
                        // final pointer cannot address a word access
                        state_d   = DONE;
                        rsp_err_d = 1'b1;
                    end else begin
                        state_d = write_q ? STORE : LOAD;
                    end
                end else if (timed_out) begin
                    state_d   = DONE;
                    rsp_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            LOAD, STORE: begin
                if (mem_resp) begin
                    state_d = DONE;
                    if (state_q == LOAD) begin
                        rsp_data_d = byte_q ? {{(DATA_W-8){1'b0}}, rdata_shifted[7:0]} : mem_rdata;
                    end
                end else if (timed_out) begin
                    state_d   = DONE;
                    rsp_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d    = IDLE;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Bus outputs are registered from the next-state view so they line up with the state.
        req_ready_d   = (state_d == IDLE);
        rsp_valid_d   = (state_d == DONE);
        mem_read_d    = (state_d == PTR) || (state_d == LOAD);
        mem_write_d   = (state_d == STORE);
        mem_address_d = (mem_read_d || mem_write_d) ? {addr_d[ADDR_W-1:LB], {LB{1'b0}}} : '0;
        mem_wdata_d   = '0;
        if (mem_write_d) begin
            mem_wdata_d = byte_d ? {NB{wdata_d[7:0]}} : wdata_d;
        end
        mem_byte_enable_d = '0;
        if (mem_read_d || (mem_write_d && !byte_d)) begin
            mem_byte_enable_d = '1;
        end else if (mem_write_d) begin
            mem_byte_enable_d = NB'(1) << addr_d[LB-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            addr_q            <= '0;
            ind_q             <= '0;
            write_q           <= 1'b0;
            byte_q            <= 1'b0;
            wdata_q           <= '0;
            wait_q            <= '0;
            rsp_data_q        <= '0;
            rsp_err_q         <= 1'b0;
            rsp_valid_q       <= 1'b0;
            req_ready_q       <= 1'b1;
            mem_read_q        <= 1'b0;
            mem_write_q       <= 1'b0;
            mem_address_q     <= '0;
            mem_wdata_q       <= '0;
            mem_byte_enable_q <= '0;
        end else begin
            state_q           <= state_d;
            addr_q            <= addr_d;
            ind_q             <= ind_d;
            write_q           <= write_d;
            byte_q            <= byte_d;
            wdata_q           <= wdata_d;
            wait_q            <= wait_d;
            rsp_data_q        <= rsp_data_d;
            rsp_err_q         <= rsp_err_d;
            rsp_valid_q       <= rsp_valid_d;
            req_ready_q       <= req_ready_d;
            mem_read_q        <= mem_read_d;
            mem_write_q       <= mem_write_d;
            mem_address_q     <= mem_address_d;
            mem_wdata_q       <= mem_wdata_d;
            mem_byte_enable_q <= mem_byte_enable_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_data        = rsp_data_q;
    assign rsp_err         = rsp_err_q;
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_address     = mem_address_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_byte_enable = mem_byte_enable_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq (DATA_W=16, ADDR_W=16, MAX_IND=2, TIMEOUT=4).
module tb_mem_access_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_byte;
    logic [1:0]  req_ind;
    logic [15:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [15:0] rsp_data;
    logic        mem_read, mem_write, mem_resp;
    logic [15:0] mem_address, mem_wdata, mem_rdata;
    logic [1:0]  mem_byte_enable;

    int total = 0;
    int bad   = 0;

    mem_access_seq #(.DATA_W(16), .ADDR_W(16), .MAX_IND(2), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_byte(req_byte), .req_ind(req_ind), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    // Strobes must be mutually exclusive on every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            total++;
            if ((mem_read && mem_write) !== 1'b0) begin
                bad++;
                $display("FAIL strobe_exclusive: read=%b write=%b want not both", mem_read, mem_write);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic wr, input logic by, input logic [1:0] ind,
                        input logic [15:0] addr, input logic [15:0] wd);
        req_valid = 1'b1; req_write = wr; req_byte = by;
        req_ind = ind; req_addr = addr; req_wdata = wd;
        step();
        req_valid = 1'b0;
    endtask

    task automatic respond(input logic [15:0] rd);
        mem_rdata = rd; mem_resp = 1'b1;
        step();
        mem_resp = 1'b0;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        total++;
        if ({req_ready, rsp_valid, rsp_err, rsp_data, mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable}
            !== {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00}) begin
            bad++;
            $display("FAIL reset_state: ready=%b valid=%b err=%b data=%h rd=%b wr=%b addr=%h wd=%h be=%b want ready=1 rest 0",
                     req_ready, rsp_valid, rsp_err, rsp_data, mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable);
        end
    endtask

    task automatic test_word_load();
        send(1'b0, 1'b0, 2'd0, 16'h0040, 16'h0);
        total++;
        if ({mem_read, mem_write, mem_address, mem_byte_enable, rsp_valid} !== {1'b1, 1'b0, 16'h0040, 2'b11, 1'b0}) begin
            bad++;
            $display("FAIL word_load_strobe: rd=%b wr=%b addr=%h be=%b valid=%b want 1 0 0040 11 0",
                     mem_read, mem_write, mem_address, mem_byte_enable, rsp_valid);
        end
        respond(16'hBEEF);
        total++;
        if ({rsp_valid, rsp_data, rsp_err, mem_read} !== {1'b1, 16'hBEEF, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL word_load_rsp: valid=%b data=%h err=%b rd=%b want 1 beef 0 0", rsp_valid, rsp_data, rsp_err, mem_read);
        end
        handshake();
        total++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            bad++;
            $display("FAIL word_load_idle: ready=%b valid=%b want 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_byte_store();
        send(1'b1, 1'b1, 2'd0, 16'h0043, 16'h12A5);
        total++;
        if ({mem_write, mem_read, mem_address, mem_wdata, mem_byte_enable} !== {1'b1, 1'b0, 16'h0042, 16'hA5A5, 2'b10}) begin
            bad++;
            $display("FAIL byte_store_strobe: wr=%b rd=%b addr=%h wd=%h be=%b want 1 0 0042 a5a5 10",
                     mem_write, mem_read, mem_address, mem_wdata, mem_byte_enable);
        end
        respond(16'h0);
        total++;
        if ({rsp_valid, rsp_err, rsp_data, mem_write} !== {1'b1, 1'b0, 16'h0, 1'b0}) begin
            bad++;
            $display("FAIL byte_store_rsp: valid=%b err=%b data=%h wr=%b want 1 0 0000 0", rsp_valid, rsp_err, rsp_data, mem_write);
        end
        handshake();
        send(1'b1, 1'b0, 2'd0, 16'h0044, 16'h5A3C);
        total++;
        if ({mem_write, mem_address, mem_wdata, mem_byte_enable} !== {1'b1, 16'h0044, 16'h5A3C, 2'b11}) begin
            bad++;
            $display("FAIL word_store_strobe: wr=%b addr=%h wd=%h be=%b want 1 0044 5a3c 11",
                     mem_write, mem_address, mem_wdata, mem_byte_enable);
        end
        respond(16'h0);
        handshake();
    endtask

    task automatic test_indirect();
        send(1'b0, 1'b1, 2'd2, 16'h0010, 16'h0);
        total++;
        if ({mem_read, mem_address, mem_byte_enable} !== {1'b1, 16'h0010, 2'b11}) begin
            bad++;
            $display("FAIL ind_ptr0: rd=%b addr=%h be=%b want 1 0010 11", mem_read, mem_address, mem_byte_enable);
        end
        respond(16'h0020);
        total++;
        if ({mem_read, mem_address, rsp_valid} !== {1'b1, 16'h0020, 1'b0}) begin
            bad++;
            $display("FAIL ind_ptr1: rd=%b addr=%h valid=%b want 1 0020 0", mem_read, mem_address, rsp_valid);
        end
        respond(16'h0031);
        total++;
        if ({mem_read, mem_address} !== {1'b1, 16'h0030}) begin
            bad++;
            $display("FAIL ind_final: rd=%b addr=%h want 1 0030", mem_read, mem_address);
        end
        respond(16'h7F00);
        total++;
        if ({rsp_valid, rsp_data, rsp_err} !== {1'b1, 16'h007F, 1'b0}) begin
            bad++;
            $display("FAIL ind_rsp: valid=%b data=%h err=%b want 1 007f 0", rsp_valid, rsp_data, rsp_err);
        end
        handshake();
        // Word final access through a misaligned pointer
        send(1'b0, 1'b0, 2'd1, 16'h0010, 16'h0);
        respond(16'h0021);
        total++;
        if ({rsp_valid, rsp_err, mem_read, rsp_data} !== {1'b1, 1'b1, 1'b0, 16'h0}) begin
            bad++;
            $display("FAIL ptr_misalign: valid=%b err=%b rd=%b data=%h want 1 1 0 0000", rsp_valid, rsp_err, mem_read, rsp_data);
        end
        handshake();
    endtask

    task automatic test_errors();
        send(1'b0, 1'b0, 2'd0, 16'h0041, 16'h0);
        total++;
        if ({mem_read, mem_write, rsp_valid, rsp_err, rsp_data} !== {1'b0, 1'b0, 1'b1, 1'b1, 16'h0}) begin
            bad++;
            $display("FAIL misalign_rsp: rd=%b wr=%b valid=%b err=%b data=%h want 0 0 1 1 0000",
                     mem_read, mem_write, rsp_valid, rsp_err, rsp_data);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({rsp_valid, rsp_err, req_ready} !== 3'b110) begin
                bad++;
                $display("FAIL misalign_hold%0d: valid=%b err=%b ready=%b want 1 1 0", i, rsp_valid, rsp_err, req_ready);
            end
        end
        handshake();
        total++;
        if ({req_ready, rsp_valid, rsp_err} !== 3'b100) begin
            bad++;
            $display("FAIL misalign_idle: ready=%b valid=%b err=%b want 1 0 0", req_ready, rsp_valid, rsp_err);
        end
        send(1'b0, 1'b0, 2'd3, 16'h0040, 16'h0);
        total++;
        if ({mem_read, rsp_valid, rsp_err} !== 3'b011) begin
            bad++;
            $display("FAIL bad_depth: rd=%b valid=%b err=%b want 0 1 1", mem_read, rsp_valid, rsp_err);
        end
        handshake();
    endtask

    task automatic test_timeout();
        send(1'b1, 1'b0, 2'd0, 16'h0050, 16'h1111);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem_write !== 1'b1) begin
                bad++;
                $display("FAIL timeout_hold%0d: wr=%b want 1", i, mem_write);
            end
            step();
        end
        total++;
        if ({mem_write, rsp_valid, rsp_err} !== 3'b011) begin
            bad++;
            $display("FAIL timeout_err: wr=%b valid=%b err=%b want 0 1 1", mem_write, rsp_valid, rsp_err);
        end
        handshake();
        send(1'b1, 1'b0, 2'd0, 16'h0050, 16'h2222);
        step(); step(); step();
        total++;
        if ({mem_write, rsp_valid} !== 2'b10) begin
            bad++;
            $display("FAIL late_resp_wait: wr=%b valid=%b want 1 0", mem_write, rsp_valid);
        end
        respond(16'h0);
        total++;
        if ({mem_write, rsp_valid, rsp_err} !== 3'b010) begin
            bad++;
            $display("FAIL late_resp_wins: wr=%b valid=%b err=%b want 0 1 0", mem_write, rsp_valid, rsp_err);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        send(1'b0, 1'b0, 2'd2, 16'h0010, 16'h0);
        total++;
        if (mem_read !== 1'b1) begin
            bad++;
            $display("FAIL mid_ptr_active: rd=%b want 1", mem_read);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if ({req_ready, mem_read, rsp_valid, mem_address} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
            bad++;
            $display("FAIL mid_reset: ready=%b rd=%b valid=%b addr=%h want 1 0 0 0000", req_ready, mem_read, rsp_valid, mem_address);
        end
        send(1'b0, 1'b0, 2'd0, 16'h0060, 16'h0);
        total++;
        if ({mem_read, mem_address} !== {1'b1, 16'h0060}) begin
            bad++;
            $display("FAIL post_reset_req: rd=%b addr=%h want 1 0060", mem_read, mem_address);
        end
        respond(16'h1234);
        total++;
        if ({rsp_valid, rsp_data, rsp_err} !== {1'b1, 16'h1234, 1'b0}) begin
            bad++;
            $display("FAIL post_reset_rsp: valid=%b data=%h err=%b want 1 1234 0", rsp_valid, rsp_data, rsp_err);
        end
        handshake();
    endtask

    task automatic test_stray_resp();
        respond(16'hFFFF);
        total++;
        if ({req_ready, rsp_valid, mem_read, mem_write} !== 4'b1000) begin
            bad++;
            $display("FAIL stray_resp: ready=%b valid=%b rd=%b wr=%b want 1 0 0 0", req_ready, rsp_valid, mem_read, mem_write);
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
        req_ind = '0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; mem_rdata = '0; mem_resp = 1'b0;
        #1;
        test_reset();
        test_word_load();
        test_byte_store();
        test_indirect();
        test_errors();
        test_timeout();
        test_reset_mid();
        test_stray_resp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
